mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request a new operation; sampled only when busy=0.
REQ-005 op  input  mult_op_enum  ALU_MULT or ALU_DIV.
REQ-006 sign  input  1  1 = signed operands, 0 = unsigned.
REQ-007 src_a  input  word_t  multiplicand / dividend (rs).
REQ-008 src_b  input  word_t  multiplier / divisor (rt).
REQ-009 hi_we, lo_we  input  1 each  MTHI / MTLO write enables.
REQ-010 wdata  input  word_t  MTHI / MTLO data.
REQ-011 busy  output  1  operation in progress.
REQ-012 done  output  1  one-cycle pulse; hi and lo hold the new result.
REQ-013 hi, lo  output  word_t  architectural HI and LO registers, read by MFHI / MFLO.

Function
REQ-014 The FSM SHALL have states IDLE, CALC and FIX; busy SHALL equal (state != IDLE).
REQ-015 In IDLE with start=1, the block SHALL latch op, sign, the operand magnitudes (absolute value when sign=1) and the result-sign flags, clear the 5-bit counter, and go to CALC.
REQ-016 CALC SHALL perform one iteration per cycle for exactly 32 cycles, then go to FIX.
- ALU_MULT: shift-add into a 64-bit accumulator.
- ALU_DIV: restoring division, 1 quotient bit per cycle.
REQ-017 FIX SHALL apply sign correction, write hi and lo, pulse done for the next cycle, and return to IDLE.
REQ-018 Latency SHALL be fixed: done=1 exactly 34 cycles after the start cycle, i.e. in the cycle after the 34th rising edge counted from the start cycle's edge, for both operations.
REQ-019 MULT results SHALL be written as hi = product[63:32] and lo = product[31:0]; the product is the full 64-bit two's-complement value when sign=1 and unsigned otherwise.
REQ-020 DIV results SHALL be written as lo = quotient and hi = remainder.
- Signed quotient truncates toward zero.
- Remainder takes the sign of the dividend.
REQ-021 For divide by zero in either signedness, the result SHALL be lo = 32'hFFFF_FFFF and hi = src_a, with no sign correction applied.
REQ-022 Signed 32'h8000_0000 / 32'hFFFF_FFFF SHALL give lo = 32'h8000_0000 and hi = 0.
REQ-023 A start asserted while busy=1 SHALL be ignored; no queueing.
REQ-024 A start asserted in the done cycle SHALL be accepted.
REQ-025 When busy=0, hi_we / lo_we SHALL write wdata to hi / lo at the next edge.
REQ-026 When busy=1, hi_we / lo_we SHALL be ignored.
REQ-027 If hi_we or lo_we coincides with an accepted start, the write SHALL take effect; the operation result later overwrites it.
REQ-028 Operand inputs SHALL NOT be required to remain stable after the start cycle.

Reset
REQ-029 While rst=1, the block SHALL force state=IDLE, busy=0, done=0, hi=ZERO, lo=ZERO, counter=0, with rst priority over start and writes.
REQ-030 Reset during CALC or FIX SHALL abandon the operation with no done pulse.

Structure
REQ-031 mdu_state_enum {IDLE, CALC, FIX} and localparam MDU_ITER = 32 SHALL be added to mips_cpu_pkg; word_t, double_word_t and mult_op_enum SHALL be reused.
REQ-032 An iterative sub-module mdu_iter (one multiply/divide step per cycle) SHALL be instantiated; sign pre- and post-processing and hi/lo stay in mul_div_unit.

Verification
REQ-033 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 34 cycles after start; busy=1 throughout the operation.
REQ-034 MULT -3 x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-035 DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-036 DIVU 100 / 0 -> lo=0xFFFFFFFF, hi=0x00000064; signed 100 / 0 gives the same.
REQ-037 Start DIVU 9/2, pulse start with other operands plus hi_we (wdata=0x55) at cycle 5, expect lo=4, hi=1 with no effect from the second start or the write.
REQ-038 Apply rst at cycle 10 of an operation -> busy=0, hi=lo=0, and no done pulse.

Source files
------------

// File: rtl/mips_cpu_pkg.sv
// Shared CPU types plus the multiply/divide unit's state encoding and iteration count.
package mips_cpu_pkg;

    typedef logic [31:0] word_t;
    typedef logic [63:0] double_word_t;

    typedef enum logic {
        ALU_MULT = 1'b0,
        ALU_DIV  = 1'b1
    } mult_op_enum;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } mdu_state_enum;

    localparam word_t ZERO     = 32'h0000_0000;
    localparam int    MDU_ITER = 32;

    // Magnitude of a word; the most negative value maps onto itself as an unsigned 2^31.
    function automatic word_t abs_word(input word_t v, input logic is_signed);
        word_t r;
        if (is_signed && v[31]) begin
            r = ~v + 32'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// One unsigned shift-add multiply step or one restoring-division step per enabled cycle.
module mdu_iter
    import mips_cpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_step,
    input  mult_op_enum  i_op,
    input  word_t        i_init,
    input  word_t        i_operand,
    output double_word_t o_acc
);

    double_word_t r_acc;
    word_t        r_operand;
    logic [32:0]  w_add;
    logic [32:0]  w_rem_shift;
    logic [32:0]  w_diff;
    double_word_t w_acc_nxt;

    // Next accumulator: multiply keeps {partial, multiplier}; divide keeps {remainder, quotient}.
    always_comb begin
        w_add       = {1'b0, r_acc[63:32]} + {1'b0, (r_acc[0] ? r_operand : ZERO)};
        w_rem_shift = r_acc[63:31];
        w_diff      = w_rem_shift - {1'b0, r_operand};
        w_acc_nxt   = r_acc;
        case (i_op)
            ALU_MULT: w_acc_nxt = {w_add, r_acc[31:1]};
            ALU_DIV: begin
                // Bit 32 of the difference is the borrow: set means the trial subtract failed.
                if (!w_diff[32]) begin
                    w_acc_nxt = {w_diff[31:0], r_acc[30:0], 1'b1};
                end else begin
                    w_acc_nxt = {w_rem_shift[31:0], r_acc[30:0], 1'b0};
                end
            end
            default: w_acc_nxt = r_acc;
        endcase
    end

    // Accumulator and operand registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= 64'd0;
            r_operand <= ZERO;
        end else if (i_load) begin
            r_acc     <= {ZERO, i_init};
            r_operand <= i_operand;
        end else if (i_step) begin
            r_acc     <= w_acc_nxt;
        end else begin
            r_acc     <= r_acc;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO; fixed 34-cycle latency.
module mul_div_unit
    import mips_cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  mult_op_enum op,
    input  logic        sign,
    input  word_t       src_a,
    input  word_t       src_b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  word_t       wdata,
    output logic        busy,
    output logic        done,
    output word_t       hi,
    output word_t       lo
);

    mdu_state_enum r_state;
    mdu_state_enum w_state_nxt;
    logic [4:0]    r_cnt;
    mult_op_enum   r_op;
    logic          r_neg_q;
    logic          r_neg_r;
    logic          r_div_zero;
    logic          r_done;
    word_t         r_hi;
    word_t         r_lo;

    logic          w_accept;
    logic          w_step;
    logic          w_fix;
    logic          w_neg_a;
    logic          w_neg_b;
    word_t         w_mag_a;
    word_t         w_mag_b;
    word_t         w_init;
    word_t         w_operand;
    double_word_t  w_acc;
    double_word_t  w_prod;
    word_t         w_quot;
    word_t         w_rem;
    word_t         w_res_hi;
    word_t         w_res_lo;

    // Operand magnitudes and routing into the iterator at start.
    always_comb begin
        w_neg_a   = sign & src_a[31];
        w_neg_b   = sign & src_b[31];
        w_mag_a   = abs_word(src_a, sign);
        w_mag_b   = abs_word(src_b, sign);
        w_init    = w_mag_a;
        w_operand = w_mag_b;
        if (op == ALU_MULT) begin
            w_init    = w_mag_b;
            w_operand = w_mag_a;
        end else begin
            w_init    = w_mag_a;
            w_operand = w_mag_b;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and step controls.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_fix       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = CALC;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            CALC: begin
                w_step = 1'b1;
                if (r_cnt == 5'(MDU_ITER - 1)) begin
                    w_state_nxt = FIX;
                end else begin
                    w_state_nxt = CALC;
                end
            end
            FIX: begin
                w_fix       = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Iteration counter and per-operation flags latched at start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= 5'd0;
            r_op       <= ALU_MULT;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
        end else if (w_accept) begin
            r_cnt      <= 5'd0;
            r_op       <= op;
            r_neg_q    <= w_neg_a ^ w_neg_b;
            r_neg_r    <= w_neg_a;
            r_div_zero <= (src_b == ZERO);
        end else if (w_step) begin
            r_cnt      <= r_cnt + 5'd1;
        end else begin
            r_cnt      <= r_cnt;
        end
    end

    mdu_iter u_iter (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_accept),
        .i_step    (w_step),
        .i_op      (r_op),
        .i_init    (w_init),
        .i_operand (w_operand),
        .o_acc     (w_acc)
    );

    // Sign correction; the remainder negation also restores a negative dividend on divide-by-zero.
    always_comb begin
        w_prod   = r_neg_q ? (~w_acc + 64'd1) : w_acc;
        w_quot   = r_div_zero ? 32'hFFFF_FFFF :
                   (r_neg_q ? (~w_acc[31:0] + 32'd1) : w_acc[31:0]);
        w_rem    = r_neg_r ? (~w_acc[63:32] + 32'd1) : w_acc[63:32];
        w_res_hi = w_prod[63:32];
        w_res_lo = w_prod[31:0];
        if (r_op == ALU_DIV) begin
            w_res_hi = w_rem;
            w_res_lo = w_quot;
        end else begin
            w_res_hi = w_prod[63:32];
            w_res_lo = w_prod[31:0];
        end
    end

    // HI/LO: operation result in FIX, MTHI/MTLO only while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= ZERO;
            r_lo <= ZERO;
        end else if (w_fix) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
        end else if (r_state == IDLE) begin
            if (hi_we) r_hi <= wdata;
            else       r_hi <= r_hi;
            if (lo_we) r_lo <= wdata;
            else       r_lo <= r_lo;
        end else begin
            r_hi <= r_hi;
            r_lo <= r_lo;
        end
    end

    // Completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_fix;
        end
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: random and directed operations against a plain-arithmetic model.
module tb_mul_div_unit;
    import mips_cpu_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    mult_op_enum op;
    logic        sign;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    exp_t        exp_q[$];
    exp_t        e;

    mul_div_unit dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .sign(sign),
        .src_a(src_a), .src_b(src_b), .hi_we(hi_we), .lo_we(lo_we),
        .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] ref_model(input logic is_div, input logic sgn,
                                              input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        if (!is_div) begin
            if (sgn) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = 64'(sa * sb);
            end else begin
                p = {32'd0, a} * {32'd0, b};
            end
            return p;
        end
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest pending expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: done with no pending operation at cycle %0d", cyc);
            end else begin
                e = exp_q.pop_front();
                check("result_hi", hi, e.hi);
                check("result_lo", lo, e.lo);
                check("done_latency", 32'(cyc), 32'(e.cyc));
                m_hi = e.hi;
                m_lo = e.lo;
            end
        end
    end

    task automatic wait_idle();
        int g = 0;
        while (busy !== 1'b0 && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 200) begin
            n_vec++;
            n_err++;
            $display("FAIL idle_timeout: busy stuck at %b", busy);
        end
    endtask

    task automatic do_op(input mult_op_enum o, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] ex, input int hold,
                         input logic whi, input logic [31:0] wd);
        exp_t t;
        wait_idle();
        start = 1'b1; op = o; sign = s; src_a = a; src_b = b; hi_we = whi; wdata = wd;
        t.hi = ex[63:32];
        t.lo = ex[31:0];
        t.cyc = cyc + 34;
        exp_q.push_back(t);
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0;
        src_a = $urandom; src_b = $urandom; sign = 1'($urandom_range(0, 1));
        op = mult_op_enum'($urandom_range(0, 1));
        if (whi) begin
            check("write_with_start", hi, wd);
            m_hi = wd;
        end
        for (int i = 0; i < hold; i++) begin
            check("busy_during_op", 32'(busy), 32'd1);
            @(posedge clk); #1;
        end
    endtask

    task automatic write_hl(input logic whi, input logic wlo, input logic [31:0] wd);
        wait_idle();
        hi_we = whi; lo_we = wlo; wdata = wd;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        if (whi) m_hi = wd;
        if (wlo) m_lo = wd;
        check("mthi", hi, m_hi);
        check("mtlo", lo, m_lo);
    endtask

    initial begin
        logic [31:0] a, b;
        logic        s;
        mult_op_enum o;
        int          g;

        rst = 1'b1; start = 1'b0; op = ALU_MULT; sign = 1'b0;
        src_a = 32'd0; src_b = 32'd0; hi_we = 1'b0; lo_we = 1'b0; wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF; start = 1'b1;
        @(posedge clk); #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        rst = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;

        // Directed cases.
        do_op(ALU_MULT, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33, 1'b0, 32'd0);
        do_op(ALU_MULT, 1'b1, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 0, 1'b0, 32'd0);
        do_op(ALU_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0, 1'b0, 32'd0);
        do_op(ALU_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 0, 1'b0, 32'd0);
        do_op(ALU_DIV, 1'b0, 32'd100, 32'd0, 64'h0000_0064_FFFF_FFFF, 0, 1'b0, 32'd0);
        do_op(ALU_DIV, 1'b1, 32'd100, 32'd0, 64'h0000_0064_FFFF_FFFF, 0, 1'b0, 32'd0);
        do_op(ALU_DIV, 1'b1, 32'hFFFF_FF9C, 32'd0, 64'hFFFF_FF9C_FFFF_FFFF, 0, 1'b0, 32'd0);
        write_hl(1'b1, 1'b0, 32'h1234_5678);
        write_hl(1'b0, 1'b1, 32'h9ABC_DEF0);

        // Start plus MTHI while busy must be ignored entirely.
        do_op(ALU_DIV, 1'b0, 32'd9, 32'd2, 64'h0000_0001_0000_0004, 0, 1'b0, 32'd0);
        repeat (4) begin @(posedge clk); #1; end
        start = 1'b1; op = ALU_MULT; sign = 1'b1; src_a = 32'd3; src_b = 32'd5;
        hi_we = 1'b1; wdata = 32'h55;
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0;
        check("busy_write_ignored", hi, m_hi);
        check("busy_mid_op", 32'(busy), 32'd1);

        // MTHI in the same cycle as an accepted start, then result overwrites it.
        do_op(ALU_MULT, 1'b0, 32'd6, 32'd7, 64'd42, 0, 1'b1, 32'hAAAA_5555);

        // Reset part-way through an operation.
        do_op(ALU_MULT, 1'b1, 32'h1234_5678, 32'h8765_4321,
              ref_model(1'b0, 1'b1, 32'h1234_5678, 32'h8765_4321), 0, 1'b0, 32'd0);
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        rst = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        repeat (40) begin @(posedge clk); #1; end

        // Randomized operations, issued back-to-back so starts land in done cycles.
        for (int n = 0; n < 40; n++) begin
            a = rand_word();
            b = rand_word();
            s = 1'($urandom_range(0, 1));
            o = mult_op_enum'($urandom_range(0, 1));
            do_op(o, s, a, b, ref_model(o == ALU_DIV, s, a, b), 0, 1'b0, 32'd0);
            if ($urandom_range(0, 7) == 0) write_hl(1'($urandom_range(0, 1)), 1'b1, $urandom);
        end

        g = 0;
        while (exp_q.size() != 0 && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d results never produced", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
